// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES column engines: widths, GF(2^8) reduction,
// FSM encoding and column select/replace over a 128-bit state (column 0 = MSBs).
package aes_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned STATE_W = 128;

    localparam logic [BYTE_W-1:0] GF_RED = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_RED : 8'h00);
    endfunction

    function automatic logic [COL_W-1:0] col_get(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         idx);
        logic [COL_W-1:0] c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic logic [STATE_W-1:0] col_put(input logic [STATE_W-1:0] s,
                                                   input logic [1:0]         idx,
                                                   input logic [COL_W-1:0]   c);
        logic [STATE_W-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_mixcol_col.sv
// Combinational InvMixColumns of one 32-bit column (byte 0 = MSB), built from
// shared xtime chains per byte.
module aes_inv_mixcol_col
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] res
);

    typedef struct packed {
        logic [BYTE_W-1:0] m9;
        logic [BYTE_W-1:0] mb;
        logic [BYTE_W-1:0] md;
        logic [BYTE_W-1:0] me;
    } inv_mul_t;

    function automatic inv_mul_t inv_mul(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x2, x4, x8;
        inv_mul_t m;
        x2   = xtime(b);
        x4   = xtime(x2);
        x8   = xtime(x4);
        m.m9 = x8 ^ b;
        m.mb = m.m9 ^ x2;
        m.md = m.m9 ^ x4;
        m.me = x8 ^ x4 ^ x2;
        return m;
    endfunction

    inv_mul_t m0, m1, m2, m3;

    assign m0 = inv_mul(col[31:24]);
    assign m1 = inv_mul(col[23:16]);
    assign m2 = inv_mul(col[15:8]);
    assign m3 = inv_mul(col[7:0]);

    // Row i uses coefficients {E,B,D,9} starting at byte i, wrapping around.
    assign res = {m0.me ^ m1.mb ^ m2.md ^ m3.m9,
                  m1.me ^ m2.mb ^ m3.md ^ m0.m9,
                  m2.me ^ m3.mb ^ m0.md ^ m1.m9,
                  m3.me ^ m0.mb ^ m1.md ^ m2.m9};

endmodule

// File: rtl/aes_inv_mixcol_serial.sv
// Serial AddRoundKey + InvMixColumns, one column per cycle with valid/ready handshakes.
// Optional AES_INVMC_LASTROUND_EN adds i_fLast to bypass InvMixColumns for a block.
module aes_inv_mixcol_serial
    import aes_pkg::*;
#(
    parameter int unsigned NCOL  = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [STATE_W-1:0] i_D,
    input  logic [STATE_W-1:0] i_Key,
`ifdef AES_INVMC_LASTROUND_EN
    input  logic               i_fLast,
`endif
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [STATE_W-1:0] o_D
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [STATE_W-1:0] work;
    logic [COL_W-1:0]   col_cur, col_new;
    logic               accept, last_col, skip_run;

    assign accept   = i_Valid && (state == ST_IDLE);
    assign last_col = (cnt == CNT_W'(NCOL - 1));

`ifdef AES_INVMC_LASTROUND_EN
    assign skip_run = i_fLast;
`else
    assign skip_run = 1'b0;
`endif

    assign col_cur = col_get(work, cnt);

    aes_inv_mixcol_col u_col (
        .col (col_cur),
        .res (col_new)
    );

    always_comb begin
        state_nxt = state;
        o_Ready   = 1'b0;
        o_Valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                o_Ready = 1'b1;
                if (accept) state_nxt = skip_run ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_col) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_Valid = 1'b1;
                if (i_Ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= i_D ^ i_Key;
                cnt  <= '0;
            end else if (state == ST_RUN) begin
                work <= col_put(work, cnt, col_new);
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

    assign o_D = work;

endmodule
